// File: rtl/cache_bus_pkg.sv
// Shared types and constants for the cache-to-memory arbiter slice.
// The CACHE_ARB_ROUND_ROBIN_EN macro selects the tie-break policy in arb_pick.
package cache_bus_pkg;

    localparam int WORD_BYTES = 4;
    localparam int STRB_W     = 4;
    localparam int DATA_W     = WORD_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE,
        I_ADDR,
        D_ADDR,
        RDATA,
        WDATA,
        WRESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/cache_mem_arbiter_arb_pick.sv
// Tie-break between ICache and DCache requests seen in IDLE.
// CACHE_ARB_ROUND_ROBIN_EN: alternate on ties; otherwise DCache always wins.
module arb_pick
    import cache_bus_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic i_gnt,
    input  logic d_gnt,
    output logic pick_d
);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    owner_t last_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= OWN_I;
        end else if (d_gnt) begin
            last_owner <= OWN_D;
        end else if (i_gnt) begin
            last_owner <= OWN_I;
        end
    end

    // On a tie the requester that did not win last time goes first.
    assign pick_d = d_req && !(i_req && (last_owner == OWN_D));
`else
    logic unused_rr;

    assign unused_rr = ^{clk, rst, i_req, i_gnt, d_gnt};
    assign pick_d    = d_req;
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between ICache refills and DCache reads/writes,
// one transaction at a time. Tie-break policy: CACHE_ARB_ROUND_ROBIN_EN.
module cache_mem_arbiter
    import cache_bus_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int BEAT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd_req,
    input  logic [31:0]       i_rd_addr,
    output logic              i_rd_gnt,
    output logic              i_rd_valid,
    output logic [31:0]       i_rd_data,
    output logic              i_rd_last,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_burst,
    input  logic [31:0]       d_addr,
    input  logic [STRB_W-1:0] d_wstrb,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_wready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_rlast,
    output logic              d_bdone,
    output logic              m_req,
    output logic              m_we,
    output logic [7:0]        m_len,
    output logic [31:0]       m_addr,
    output logic [STRB_W-1:0] m_wstrb,
    input  logic              m_addr_ok,
    output logic              m_wvalid,
    output logic [31:0]       m_wdata,
    output logic              m_wlast,
    input  logic              m_wready,
    input  logic              m_rvalid,
    input  logic [31:0]       m_rdata,
    input  logic              m_rlast,
    input  logic              m_bvalid
);

    localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

    arb_state_t        state;
    owner_t            owner;
    logic [BEAT_W-1:0] beat_cnt;
    logic              pick_d;
    logic              rd_to_i;
    logic              rd_to_d;
    logic              in_wdata;

    arb_pick u_pick (
        .clk    (clk),
        .rst    (rst),
        .i_req  (i_rd_req),
        .d_req  (d_req),
        .i_gnt  (i_rd_gnt),
        .d_gnt  (d_gnt),
        .pick_d (pick_d)
    );

    // Address-phase fields are captured in IDLE and held until memory accepts them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_D;
            beat_cnt <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_len    <= '0;
            m_addr   <= '0;
            m_wstrb  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        owner   <= OWN_D;
                        state   <= D_ADDR;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_len   <= d_burst ? LINE_LEN : 8'd0;
                        m_addr  <= d_addr;
                        m_wstrb <= d_we ? d_wstrb : '0;
                    end else if (i_rd_req) begin
                        owner   <= OWN_I;
                        state   <= I_ADDR;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_len   <= LINE_LEN;
                        m_addr  <= i_rd_addr;
                        m_wstrb <= '0;
                    end
                end
                I_ADDR, D_ADDR: begin
                    if (m_addr_ok) begin
                        beat_cnt <= m_len[BEAT_W-1:0];
                        state    <= m_we ? WDATA : RDATA;
                        m_req    <= 1'b0;
                        m_we     <= 1'b0;
                        m_len    <= '0;
                        m_addr   <= '0;
                    end
                end
                RDATA: begin
                    if (m_rvalid && m_rlast) begin
                        state <= IDLE;
                    end
                end
                WDATA: begin
                    if (m_wready) begin
                        if (beat_cnt == '0) begin
                            state   <= WRESP;
                            m_wstrb <= '0;
                        end else begin
                            beat_cnt <= beat_cnt - 1'b1;
                        end
                    end
                end
                WRESP: begin
                    if (m_bvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_to_i  = (state == RDATA) && (owner == OWN_I);
    assign rd_to_d  = (state == RDATA) && (owner == OWN_D);
    assign in_wdata = (state == WDATA);

    assign i_rd_gnt   = (state == I_ADDR) && m_addr_ok;
    assign d_gnt      = (state == D_ADDR) && m_addr_ok;

    // Read beats go straight through to the owner; the other side sees zeros.
    assign i_rd_valid = rd_to_i && m_rvalid;
    assign i_rd_data  = rd_to_i ? m_rdata : '0;
    assign i_rd_last  = rd_to_i && m_rlast;
    assign d_rvalid   = rd_to_d && m_rvalid;
    assign d_rdata    = rd_to_d ? m_rdata : '0;
    assign d_rlast    = rd_to_d && m_rlast;

    assign m_wvalid   = in_wdata;
    assign m_wdata    = in_wdata ? d_wdata : '0;
    assign m_wlast    = in_wdata && (beat_cnt == '0);
    assign d_wready   = in_wdata && m_wready;
    assign d_bdone    = (state == WRESP) && m_bvalid;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed testbench for cache_mem_arbiter; expectations are hand-computed.
module tb_cache_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_rd_req;
    logic [31:0] i_rd_addr;
    logic        i_rd_gnt, i_rd_valid, i_rd_last;
    logic [31:0] i_rd_data;
    logic        d_req, d_we, d_burst;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt, d_wready, d_rvalid, d_rlast, d_bdone;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [7:0]  m_len;
    logic [31:0] m_addr;
    logic [3:0]  m_wstrb;
    logic        m_addr_ok;
    logic        m_wvalid, m_wlast, m_wready;
    logic [31:0] m_wdata;
    logic        m_rvalid, m_rlast, m_bvalid;
    logic [31:0] m_rdata;

    int n_compared;
    int n_mismatched;

    cache_mem_arbiter #(.LINE_WORDS(8), .BEAT_W(4)) dut (
        .clk(clk), .rst(rst),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_gnt(i_rd_gnt),
        .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data), .i_rd_last(i_rd_last),
        .d_req(d_req), .d_we(d_we), .d_burst(d_burst), .d_addr(d_addr),
        .d_wstrb(d_wstrb), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_wready(d_wready),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_bdone(d_bdone),
        .m_req(m_req), .m_we(m_we), .m_len(m_len), .m_addr(m_addr), .m_wstrb(m_wstrb),
        .m_addr_ok(m_addr_ok), .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wlast(m_wlast),
        .m_wready(m_wready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .m_bvalid(m_bvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plays memory read beats base+k; starts on the current negedge, ends one negedge after the last beat.
    task automatic mem_read_beats(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            m_rvalid = 1'b1;
            m_rdata  = base + 32'(k);
            m_rlast  = (k == n - 1);
        end
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        i_rd_req = 1'b1;
        i_rd_addr = 32'h0000_0040;
        @(negedge clk);
        #1;
        n_compared++; if (m_req !== 1'b0) begin n_mismatched++; $display("FAIL reset_m_req: got %0b want 0", m_req); end
        n_compared++; if (m_addr !== 32'h0) begin n_mismatched++; $display("FAIL reset_m_addr: got %h want 0", m_addr); end
        n_compared++; if (m_len !== 8'h0) begin n_mismatched++; $display("FAIL reset_m_len: got %h want 0", m_len); end
        n_compared++; if ({i_rd_gnt, d_gnt, m_wvalid, d_bdone, i_rd_valid, d_rvalid} !== 6'b0) begin n_mismatched++; $display("FAIL reset_pulses: got %b want 000000", {i_rd_gnt, d_gnt, m_wvalid, d_bdone, i_rd_valid, d_rvalid}); end
        i_rd_req = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_icache_refill();
        @(negedge clk);
        i_rd_req  = 1'b1;
        i_rd_addr = 32'h0000_1000;
        #1;
        n_compared++; if (m_req !== 1'b0) begin n_mismatched++; $display("FAIL refill_no_early_req: got %0b want 0", m_req); end
        @(negedge clk);
        #1;
        n_compared++; if (m_req !== 1'b1) begin n_mismatched++; $display("FAIL refill_m_req: got %0b want 1", m_req); end
        n_compared++; if (m_len !== 8'd7) begin n_mismatched++; $display("FAIL refill_m_len: got %0d want 7", m_len); end
        n_compared++; if (m_addr !== 32'h0000_1000) begin n_mismatched++; $display("FAIL refill_m_addr: got %h want 00001000", m_addr); end
        n_compared++; if (m_we !== 1'b0) begin n_mismatched++; $display("FAIL refill_m_we: got %0b want 0", m_we); end
        n_compared++; if (i_rd_gnt !== 1'b0) begin n_mismatched++; $display("FAIL refill_gnt_early: got %0b want 0", i_rd_gnt); end
        @(negedge clk);
        #1;
        n_compared++; if (m_req !== 1'b1) begin n_mismatched++; $display("FAIL refill_req_held: got %0b want 1", m_req); end
        @(negedge clk);
        m_addr_ok = 1'b1;
        #1;
        n_compared++; if (i_rd_gnt !== 1'b1) begin n_mismatched++; $display("FAIL refill_gnt: got %0b want 1", i_rd_gnt); end
        n_compared++; if (d_gnt !== 1'b0) begin n_mismatched++; $display("FAIL refill_d_gnt: got %0b want 0", d_gnt); end
        @(negedge clk);
        m_addr_ok = 1'b0;
        i_rd_req  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            m_rvalid = 1'b1;
            m_rdata  = 32'h11 * (k + 1);
            m_rlast  = (k == 7);
            #1;
            n_compared++; if (i_rd_valid !== 1'b1) begin n_mismatched++; $display("FAIL refill_valid beat %0d: got %0b want 1", k, i_rd_valid); end
            n_compared++; if (i_rd_data !== 32'(32'h11 * (k + 1))) begin n_mismatched++; $display("FAIL refill_data beat %0d: got %h want %h", k, i_rd_data, 32'h11 * (k + 1)); end
            n_compared++; if (i_rd_last !== (k == 7)) begin n_mismatched++; $display("FAIL refill_last beat %0d: got %0b want %0b", k, i_rd_last, (k == 7)); end
            n_compared++; if ({d_rvalid, i_rd_gnt, m_req} !== 3'b0) begin n_mismatched++; $display("FAIL refill_quiet beat %0d: got %b want 000", k, {d_rvalid, i_rd_gnt, m_req}); end
        end
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rdata  = '0;
        #1;
        n_compared++; if (i_rd_valid !== 1'b0) begin n_mismatched++; $display("FAIL refill_done_valid: got %0b want 0", i_rd_valid); end
    endtask

    task automatic test_tie();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_burst = 1'b0; d_addr = 32'h0000_2000;
        i_rd_req = 1'b1; i_rd_addr = 32'h0000_3000;
        @(negedge clk);
        #1;
        n_compared++; if (m_addr !== 32'h0000_2000) begin n_mismatched++; $display("FAIL tie1_addr: got %h want 00002000", m_addr); end
        n_compared++; if (m_len !== 8'd0) begin n_mismatched++; $display("FAIL tie1_len: got %0d want 0", m_len); end
        m_addr_ok = 1'b1;
        #1;
        n_compared++; if ({d_gnt, i_rd_gnt} !== 2'b10) begin n_mismatched++; $display("FAIL tie1_gnt: got %b want 10", {d_gnt, i_rd_gnt}); end
        @(negedge clk);
        m_addr_ok = 1'b0;
        d_addr = 32'h0000_2040;
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hCAFE_0001;
        #1;
        n_compared++; if ({d_rvalid, d_rlast} !== 2'b11) begin n_mismatched++; $display("FAIL tie1_rvalid: got %b want 11", {d_rvalid, d_rlast}); end
        n_compared++; if (d_rdata !== 32'hCAFE_0001) begin n_mismatched++; $display("FAIL tie1_rdata: got %h want cafe0001", d_rdata); end
        n_compared++; if (i_rd_valid !== 1'b0) begin n_mismatched++; $display("FAIL tie1_i_quiet: got %0b want 0", i_rd_valid); end
        @(negedge clk);
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
        #1;
        n_compared++; if ({m_req, d_gnt, i_rd_gnt} !== 3'b0) begin n_mismatched++; $display("FAIL tie_idle_gap: got %b want 000", {m_req, d_gnt, i_rd_gnt}); end
        @(negedge clk);
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        #1;
        n_compared++; if (m_addr !== 32'h0000_3000) begin n_mismatched++; $display("FAIL tie2_addr: got %h want 00003000", m_addr); end
        m_addr_ok = 1'b1;
        #1;
        n_compared++; if ({d_gnt, i_rd_gnt} !== 2'b01) begin n_mismatched++; $display("FAIL tie2_gnt: got %b want 01", {d_gnt, i_rd_gnt}); end
        @(negedge clk);
        m_addr_ok = 1'b0; i_rd_req = 1'b0;
        mem_read_beats(8, 32'h0000_0100);
        @(negedge clk);
        #1;
        n_compared++; if (m_addr !== 32'h0000_2040) begin n_mismatched++; $display("FAIL tie2_d_addr: got %h want 00002040", m_addr); end
        m_addr_ok = 1'b1;
        #1;
        n_compared++; if (d_gnt !== 1'b1) begin n_mismatched++; $display("FAIL tie2_d_gnt: got %0b want 1", d_gnt); end
        @(negedge clk);
        m_addr_ok = 1'b0; d_req = 1'b0;
        mem_read_beats(1, 32'h0000_0200);
`else
        #1;
        n_compared++; if (m_addr !== 32'h0000_2040) begin n_mismatched++; $display("FAIL tie2_addr: got %h want 00002040", m_addr); end
        m_addr_ok = 1'b1;
        #1;
        n_compared++; if ({d_gnt, i_rd_gnt} !== 2'b10) begin n_mismatched++; $display("FAIL tie2_gnt: got %b want 10", {d_gnt, i_rd_gnt}); end
        @(negedge clk);
        m_addr_ok = 1'b0; d_req = 1'b0;
        mem_read_beats(1, 32'h0000_0200);
        @(negedge clk);
        #1;
        n_compared++; if (m_addr !== 32'h0000_3000) begin n_mismatched++; $display("FAIL tie_i_addr: got %h want 00003000", m_addr); end
        n_compared++; if (m_len !== 8'd7) begin n_mismatched++; $display("FAIL tie_i_len: got %0d want 7", m_len); end
        m_addr_ok = 1'b1;
        #1;
        n_compared++; if ({d_gnt, i_rd_gnt} !== 2'b01) begin n_mismatched++; $display("FAIL tie_i_gnt: got %b want 01", {d_gnt, i_rd_gnt}); end
        @(negedge clk);
        m_addr_ok = 1'b0; i_rd_req = 1'b0;
        mem_read_beats(8, 32'h0000_0100);
`endif
    endtask

    task automatic test_single_write();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_burst = 1'b0; d_addr = 32'h1FC0_0004;
        d_wstrb = 4'b0011; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        #1;
        n_compared++; if ({m_req, m_we} !== 2'b11) begin n_mismatched++; $display("FAIL sw_req_we: got %b want 11", {m_req, m_we}); end
        n_compared++; if (m_len !== 8'd0) begin n_mismatched++; $display("FAIL sw_len: got %0d want 0", m_len); end
        n_compared++; if (m_addr !== 32'h1FC0_0004) begin n_mismatched++; $display("FAIL sw_addr: got %h want 1fc00004", m_addr); end
        n_compared++; if (m_wstrb !== 4'b0011) begin n_mismatched++; $display("FAIL sw_wstrb: got %b want 0011", m_wstrb); end
        m_addr_ok = 1'b1;
        #1;
        n_compared++; if (d_gnt !== 1'b1) begin n_mismatched++; $display("FAIL sw_gnt: got %0b want 1", d_gnt); end
        @(negedge clk);
        m_addr_ok = 1'b0; d_req = 1'b0; m_wready = 1'b0;
        #1;
        n_compared++; if ({m_wvalid, m_wlast, d_wready} !== 3'b110) begin n_mismatched++; $display("FAIL sw_wbeat: got %b want 110", {m_wvalid, m_wlast, d_wready}); end
        n_compared++; if (m_wdata !== 32'hDEAD_BEEF) begin n_mismatched++; $display("FAIL sw_wdata: got %h want deadbeef", m_wdata); end
        @(negedge clk);
        m_wready = 1'b1;
        #1;
        n_compared++; if (d_wready !== 1'b1) begin n_mismatched++; $display("FAIL sw_wready: got %0b want 1", d_wready); end
        @(negedge clk);
        m_wready = 1'b0;
        #1;
        n_compared++; if ({m_wvalid, d_bdone} !== 2'b00) begin n_mismatched++; $display("FAIL sw_wresp_wait: got %b want 00", {m_wvalid, d_bdone}); end
        @(negedge clk);
        m_bvalid = 1'b1;
        #1;
        n_compared++; if (d_bdone !== 1'b1) begin n_mismatched++; $display("FAIL sw_bdone: got %0b want 1", d_bdone); end
        @(negedge clk);
        m_bvalid = 1'b0;
        #1;
        n_compared++; if ({d_bdone, m_req} !== 2'b00) begin n_mismatched++; $display("FAIL sw_after: got %b want 00", {d_bdone, m_req}); end
    endtask

    task automatic test_burst_write();
        int beat;
        int pulses;
        beat = 0;
        pulses = 0;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_burst = 1'b1; d_addr = 32'h0000_4000;
        d_wstrb = 4'b1111; d_wdata = 32'hA000_0000;
        @(negedge clk);
        #1;
        n_compared++; if (m_len !== 8'd7) begin n_mismatched++; $display("FAIL bw_len: got %0d want 7", m_len); end
        m_addr_ok = 1'b1;
        #1;
        n_compared++; if (d_gnt !== 1'b1) begin n_mismatched++; $display("FAIL bw_gnt: got %0b want 1", d_gnt); end
        @(negedge clk);
        m_addr_ok = 1'b0; d_req = 1'b0;
        for (int cyc = 0; cyc < 40 && beat < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            m_wready = cyc[0];
            d_wdata  = 32'hA000_0000 + 32'(beat);
            #1;
            n_compared++; if (m_wdata !== 32'hA000_0000 + 32'(beat)) begin n_mismatched++; $display("FAIL bw_wdata beat %0d: got %h want %h", beat, m_wdata, 32'hA000_0000 + 32'(beat)); end
            n_compared++; if (m_wlast !== (beat == 7)) begin n_mismatched++; $display("FAIL bw_wlast beat %0d: got %0b want %0b", beat, m_wlast, (beat == 7)); end
            n_compared++; if (d_wready !== cyc[0]) begin n_mismatched++; $display("FAIL bw_wready cyc %0d: got %0b want %0b", cyc, d_wready, cyc[0]); end
            if (d_wready === 1'b1) begin
                pulses++;
                beat++;
            end
        end
        @(negedge clk);
        m_wready = 1'b1;
        #1;
        n_compared++; if (pulses !== 8) begin n_mismatched++; $display("FAIL bw_pulses: got %0d want 8", pulses); end
        n_compared++; if ({m_wvalid, d_wready} !== 2'b00) begin n_mismatched++; $display("FAIL bw_after_last: got %b want 00", {m_wvalid, d_wready}); end
        m_wready = 1'b0;
        m_bvalid = 1'b1;
        #1;
        n_compared++; if (d_bdone !== 1'b1) begin n_mismatched++; $display("FAIL bw_bdone: got %0b want 1", d_bdone); end
        @(negedge clk);
        m_bvalid = 1'b0;
    endtask

    task automatic test_spurious();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'h5A5A_0000 + 32'(k);
            m_bvalid = 1'b1; m_wready = 1'b1;
            #1;
            n_compared++; if ({i_rd_valid, d_rvalid, i_rd_last, d_rlast, d_bdone, d_wready, m_req} !== 7'b0) begin n_mismatched++; $display("FAIL spurious cyc %0d: got %b want 0000000", k, {i_rd_valid, d_rvalid, i_rd_last, d_rlast, d_bdone, d_wready, m_req}); end
            n_compared++; if ({i_rd_data, d_rdata} !== 64'h0) begin n_mismatched++; $display("FAIL spurious_data cyc %0d: got %h want 0", k, {i_rd_data, d_rdata}); end
        end
        @(negedge clk);
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_bvalid = 1'b0; m_wready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_addr = 32'h0000_5000;
        @(negedge clk);
        m_addr_ok = 1'b1;
        #1;
        n_compared++; if (i_rd_gnt !== 1'b1) begin n_mismatched++; $display("FAIL rm_gnt: got %0b want 1", i_rd_gnt); end
        @(negedge clk);
        m_addr_ok = 1'b0; i_rd_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = 32'h7700_0000 + 32'(k);
        end
        @(negedge clk);
        m_rdata = 32'h7700_0003;
        rst = 1'b1;
        #1;
        n_compared++; if ({i_rd_valid, d_rvalid, m_req, i_rd_gnt, d_gnt, m_wvalid} !== 6'b0) begin n_mismatched++; $display("FAIL rm_outputs: got %b want 000000", {i_rd_valid, d_rvalid, m_req, i_rd_gnt, d_gnt, m_wvalid}); end
        n_compared++; if (i_rd_data !== 32'h0) begin n_mismatched++; $display("FAIL rm_data: got %h want 0", i_rd_data); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 4; k < 8; k++) begin
            if (k > 4) @(negedge clk);
            m_rvalid = 1'b1; m_rlast = (k == 7); m_rdata = 32'h7700_0000 + 32'(k);
            #1;
            n_compared++; if ({i_rd_valid, i_rd_last, d_rvalid, m_req} !== 4'b0) begin n_mismatched++; $display("FAIL rm_leftover beat %0d: got %b want 0000", k, {i_rd_valid, i_rd_last, d_rvalid, m_req}); end
        end
        @(negedge clk);
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
    endtask

    initial begin
        n_compared = 0;
        n_mismatched = 0;
        rst = 1'b1;
        i_rd_req = 1'b0; i_rd_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_burst = 1'b0; d_addr = '0; d_wstrb = '0; d_wdata = '0;
        m_addr_ok = 1'b0; m_wready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0; m_bvalid = 1'b0;
        test_reset();
        test_icache_refill();
        test_tie();
        test_single_write();
        test_burst_write();
        test_spurious();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
